// File: rtl/note_pkg.sv
// note_pkg: shared types and constants for the pitch-to-note controller.
//   note_code_t   : packed note code {letter[2:0], acc[1:0], oct[2:0]}
//   note_result_t : classification result (silence flag + note code)
//   state_t       : main FSM states
//   BASE_FREQ     : lower semitone boundaries of the 440..879 Hz reference octave
//   NOTE_MAP      : {letter, acc} for each semitone index
package note_pkg;

    typedef struct packed {
        logic [2:0] letter;
        logic [1:0] acc;
        logic [2:0] oct;
    } note_code_t;

    typedef struct packed {
        logic       silent;
        note_code_t code;
    } note_result_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FOLD   = 2'd1,
        SEARCH = 2'd2,
        DECIDE = 2'd3
    } state_t;

    localparam logic [10:0] REF_LO = 11'd440;
    localparam logic [10:0] REF_HI = 11'd880;

    localparam logic [9:0] BASE_FREQ [12] = '{
        10'd440, 10'd466, 10'd494, 10'd523, 10'd554, 10'd587,
        10'd622, 10'd659, 10'd698, 10'd740, 10'd784, 10'd831
    };

    // {letter[2:0], acc[1:0]}: A, A#, B, C, C#, D, D#, E, F, F#, G, G#
    localparam logic [4:0] NOTE_MAP [12] = '{
        5'b000_00, 5'b000_01, 5'b001_00, 5'b010_00, 5'b010_01, 5'b011_00,
        5'b011_01, 5'b100_00, 5'b101_00, 5'b101_01, 5'b110_00, 5'b110_01
    };

    localparam note_result_t SILENCE = '{silent: 1'b1, code: 8'h00};

endpackage

// File: rtl/note_track_ctrl_debounce.sv
// note_debounce: publishes a classification only after STABLE_COUNT
// consecutive identical results, and only when it differs from what is
// already published.
//   clk, rst_n      : clock, asynchronous active-low reset
//   result_strobe   : one-cycle strobe, result is valid
//   result          : classification from the main FSM
//   note_code       : committed note code (0 for silence)
//   note_silent     : committed state is silence
//   note_valid      : one-cycle pulse on each new commit
module note_debounce
    import note_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         result_strobe,
    input  note_result_t result,
    output logic [7:0]   note_code,
    output logic         note_silent,
    output logic         note_valid
);

    note_result_t cand_r;
    logic [3:0]   count_r;
    logic [7:0]   code_r;
    logic         silent_r;
    logic         valid_r;

    logic [3:0]   count_next_s;
    logic         commit_s;

    // Next match count (saturating at 15) and commit decision for this result.
    always_comb begin
        count_next_s = 4'd1;
        commit_s     = 1'b0;
        if (result == cand_r) begin
            if (count_r == 4'd15) begin
                count_next_s = 4'd15;
            end else begin
                count_next_s = count_r + 4'd1;
            end
        end else begin
            count_next_s = 4'd1;
        end
        if ((count_next_s == 4'(STABLE_COUNT)) &&
            (result != note_result_t'({silent_r, code_r}))) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Candidate tracking and registered publication of committed notes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r   <= SILENCE;
            count_r  <= 4'd0;
            code_r   <= 8'h00;
            silent_r <= 1'b1;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (result_strobe) begin
                cand_r  <= result;
                count_r <= count_next_s;
                if (commit_s) begin
                    code_r   <= result.code;
                    silent_r <= result.silent;
                    valid_r  <= 1'b1;
                end
            end
        end
    end

    assign note_code   = code_r;
    assign note_silent = silent_r;
    assign note_valid  = valid_r;

endmodule

// File: rtl/note_track_ctrl.sv
// note_track_ctrl: accepts frequency samples, folds them into the
// 440..879 Hz reference octave, classifies against the semitone table with
// one shared comparator, and hands results to the debouncer.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   freq_in          : frequency sample (Hz), qualified by freq_valid_in
//   freq_ready_out   : high in IDLE, a sample may be transferred
//   note_code_out    : committed note {letter, acc, octave band}
//   note_silent_out  : committed state is silence
//   note_valid_out   : one-cycle pulse per new commit
//   busy_out         : FSM is processing a sample
module note_track_ctrl
    import note_pkg::*;
#(
    parameter int unsigned FREQ_W       = 32,
    parameter int unsigned STABLE_COUNT = 3,
    parameter int unsigned MIN_FREQ     = 28,
    parameter int unsigned MAX_FREQ     = 7040
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              freq_valid_in,
    output logic              freq_ready_out,
    output logic [7:0]        note_code_out,
    output logic              note_silent_out,
    output logic              note_valid_out,
    output logic              busy_out
);

    state_t            state_r;
    logic [FREQ_W-1:0] f_r;
    logic [2:0]        oct_r;
    logic [3:0]        idx_r;
    logic [3:0]        sel_r;
    logic              silent_r;
    note_result_t      result_r;
    logic              strobe_r;
    logic              ready_r;
    logic              busy_r;

    // Main FSM: fold, sequential table search, and result hand-off.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r  <= IDLE;
            f_r      <= '0;
            oct_r    <= 3'd4;
            idx_r    <= 4'd0;
            sel_r    <= 4'd0;
            silent_r <= 1'b0;
            result_r <= SILENCE;
            strobe_r <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            strobe_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (freq_valid_in && ready_r) begin
                        f_r     <= freq_in;
                        oct_r   <= 3'd4;
                        idx_r   <= 4'd0;
                        sel_r   <= 4'd0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if ((freq_in < FREQ_W'(MIN_FREQ)) || (freq_in >= FREQ_W'(MAX_FREQ))) begin
                            silent_r <= 1'b1;
                            state_r  <= DECIDE;
                        end else begin
                            silent_r <= 1'b0;
                            state_r  <= FOLD;
                        end
                    end
                end
                FOLD: begin
                    // Band limits keep oct_r within 0..7, so no wrap is possible.
                    if (f_r >= FREQ_W'(REF_HI)) begin
                        f_r   <= f_r >> 1;
                        oct_r <= oct_r + 3'd1;
                    end else if (f_r < FREQ_W'(REF_LO)) begin
                        f_r   <= f_r << 1;
                        oct_r <= oct_r - 3'd1;
                    end else begin
                        idx_r   <= 4'd0;
                        state_r <= SEARCH;
                    end
                end
                SEARCH: begin
                    // Ascending table: last passing index is the floor match.
                    if (f_r >= FREQ_W'(BASE_FREQ[idx_r])) begin
                        sel_r <= idx_r;
                    end
                    if (idx_r == 4'd11) begin
                        state_r <= DECIDE;
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                DECIDE: begin
                    if (silent_r) begin
                        result_r <= SILENCE;
                    end else begin
                        result_r <= '{silent: 1'b0, code: {NOTE_MAP[sel_r], oct_r}};
                    end
                    strobe_r <= 1'b1;
                    ready_r  <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign freq_ready_out = ready_r;
    assign busy_out       = busy_r;

    note_debounce #(
        .STABLE_COUNT (STABLE_COUNT)
    ) u_debounce (
        .clk           (clk_in),
        .rst_n         (rst_n_in),
        .result_strobe (strobe_r),
        .result        (result_r),
        .note_code     (note_code_out),
        .note_silent   (note_silent_out),
        .note_valid    (note_valid_out)
    );

endmodule

// File: tb/tb_note_track_ctrl.sv
// Self-checking bench for note_track_ctrl: a table of samples with expected
// pulse count, committed outputs and latency, plus a mid-search reset
// sequence.
module tb_note_track_ctrl;

    typedef struct {
        logic [31:0] freq;
        int          pulses;
        logic [7:0]  code;
        logic        silent;
        int          lat;      // 0: latency not checked
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [31:0] freq_in = 32'd0;
    logic        freq_valid_in = 1'b0;
    logic        freq_ready_out;
    logic [7:0]  note_code_out;
    logic        note_silent_out;
    logic        note_valid_out;
    logic        busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    note_track_ctrl #(
        .FREQ_W       (32),
        .STABLE_COUNT (3),
        .MIN_FREQ     (28),
        .MAX_FREQ     (7040)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .freq_in         (freq_in),
        .freq_valid_in   (freq_valid_in),
        .freq_ready_out  (freq_ready_out),
        .note_code_out   (note_code_out),
        .note_silent_out (note_silent_out),
        .note_valid_out  (note_valid_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [31:0] f, input int p, input logic [7:0] c,
                                input logic s, input int l);
        vec_t v;
        v.freq = f; v.pulses = p; v.code = c; v.silent = s; v.lat = l;
        vecs.push_back(v);
    endfunction

    // Called at a negedge; ends at a negedge.
    task automatic send_sample(input vec_t v);
        int   pulses = 0;
        int   lat = 0;
        int   waits = 0;
        vec_t e;
        exp_q.push_back(v);
        freq_in       = v.freq;
        freq_valid_in = 1'b1;
        while (!freq_ready_out && waits < 50) begin
            @(negedge clk_in);
            waits++;
        end
        check("ready_wait", 32'(waits < 50), 32'd1);
        @(posedge clk_in);
        @(negedge clk_in);
        freq_valid_in = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (note_valid_out) begin
                pulses++;
                if (lat == 0) lat = k;
            end
        end
        e = exp_q.pop_front();
        check($sformatf("pulses f=%0d", e.freq), 32'(pulses), 32'(e.pulses));
        check($sformatf("code f=%0d", e.freq), 32'(note_code_out), 32'(e.code));
        check($sformatf("silent f=%0d", e.freq), 32'(note_silent_out), 32'(e.silent));
        check("busy_idle", 32'(busy_out), 32'd0);
        if (e.lat != 0) check($sformatf("latency f=%0d", e.freq), 32'(lat), 32'(e.lat));
    endtask

    initial begin
        // Alternating: never commits
        add(440, 0, 8'h00, 1'b1, 0); add(220, 0, 8'h00, 1'b1, 0);
        add(440, 0, 8'h00, 1'b1, 0); add(220, 0, 8'h00, 1'b1, 0);
        // 440 x3 commits A4
        add(440, 0, 8'h00, 1'b1, 0); add(440, 0, 8'h00, 1'b1, 0); add(440, 1, 8'h04, 1'b0, 15);
        // 20 Hz x3 commits silence
        add(20, 0, 8'h04, 1'b0, 0); add(20, 0, 8'h04, 1'b0, 0); add(20, 1, 8'h00, 1'b1, 2);
        add(440, 0, 8'h00, 1'b1, 0); add(440, 0, 8'h00, 1'b1, 0); add(440, 1, 8'h04, 1'b0, 15);
        // 7040 Hz is silence as well
        add(7040, 0, 8'h04, 1'b0, 0); add(7040, 0, 8'h04, 1'b0, 0); add(7040, 1, 8'h00, 1'b1, 2);
        // 1046 -> C5, fourth repeat does not re-pulse
        add(1046, 0, 8'h00, 1'b1, 0); add(1046, 0, 8'h00, 1'b1, 0);
        add(1046, 1, 8'h45, 1'b0, 16); add(1046, 0, 8'h45, 1'b0, 0);
        // 100 -> 800, oct 1 -> G1
        add(100, 0, 8'h45, 1'b0, 0); add(100, 0, 8'h45, 1'b0, 0); add(100, 1, 8'hC1, 1'b0, 18);
        // 28 lowest in-range -> A0 (code 0 but not silent)
        add(28, 0, 8'hC1, 1'b0, 0); add(28, 0, 8'hC1, 1'b0, 0); add(28, 1, 8'h00, 1'b0, 19);
        // 27 below range -> silence
        add(27, 0, 8'h00, 1'b0, 0); add(27, 0, 8'h00, 1'b0, 0); add(27, 1, 8'h00, 1'b1, 2);
        // 7039 highest in-range -> 879, oct 7 -> G#7
        add(7039, 0, 8'h00, 1'b1, 0); add(7039, 0, 8'h00, 1'b1, 0); add(7039, 1, 8'hCF, 1'b0, 18);
        // 879 no fold -> G#4; 880 one fold -> A5
        add(879, 0, 8'hCF, 1'b0, 0); add(879, 0, 8'hCF, 1'b0, 0); add(879, 1, 8'hCC, 1'b0, 15);
        add(880, 0, 8'hCC, 1'b0, 0); add(880, 0, 8'hCC, 1'b0, 0); add(880, 1, 8'h05, 1'b0, 16);

        // Reset state
        #12;
        @(negedge clk_in);
        check("rst_code", 32'(note_code_out), 32'h00);
        check("rst_silent", 32'(note_silent_out), 32'd1);
        check("rst_valid", 32'(note_valid_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check("rst_ready", 32'(freq_ready_out), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            send_sample(vecs[i]);
        end

        // Two samples of 440 build a candidate, third is aborted by reset mid-search
        begin
            vec_t v;
            v.freq = 440; v.pulses = 0; v.code = 8'h05; v.silent = 1'b0; v.lat = 0;
            send_sample(v);
            send_sample(v);
        end
        freq_in       = 32'd440;
        freq_valid_in = 1'b1;
        @(posedge clk_in);
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        check("abort_busy", 32'(busy_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        check("abort_code", 32'(note_code_out), 32'h00);
        check("abort_silent", 32'(note_silent_out), 32'd1);
        check("abort_valid", 32'(note_valid_out), 32'd0);
        check("abort_busy_clr", 32'(busy_out), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        check("abort_ready", 32'(freq_ready_out), 32'd1);
        // Count restarts: commit needs three fresh samples
        begin
            vec_t v;
            v.freq = 440; v.pulses = 0; v.code = 8'h00; v.silent = 1'b1; v.lat = 0;
            send_sample(v);
            send_sample(v);
            v.pulses = 1; v.code = 8'h04; v.silent = 1'b0; v.lat = 15;
            send_sample(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_track_ctrl.md
Name: note_track_ctrl

Overview:
- Sequential controller for pitch-to-note classification, sitting between the pitch detector (frequency estimates) and the display/scoring logic (note codes).
- Accepts one frequency sample per valid/ready handshake and folds it into the 440–879 Hz reference octave by repeated shifting.
- Classifies the folded value against a 12-entry semitone table, one compare per cycle, sharing a single comparator.
- Debounces the result and publishes a note only after STABLE_COUNT consecutive identical classifications.

Parameters:
- FREQ_W, 32: frequency input width, integer Hz.
- STABLE_COUNT, 3: consecutive identical classifications required to commit; legal range 1..15.
- MIN_FREQ, 28: frequencies below this value classify as silence.
- MAX_FREQ, 7040: frequencies at or above this value classify as silence (band would exceed 7).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- freq_in  input  FREQ_W  frequency sample, Hz.
- freq_valid_in  input  1  freq_in valid.
- freq_ready_out  output  1  block can accept a sample.
- note_code_out  output  8  committed note: [7:5] letter (A=0..G=6), [4:3] accidental (00 natural, 01 sharp), [2:0] octave band.
- note_silent_out  output  1  committed state is silence.
- note_valid_out  output  1  one-cycle pulse on each new commit.
- busy_out  output  1  FSM not in IDLE.

Behaviour:
- Reset is asynchronous on rst_n_in low. All of the following clear immediately:
  - note_code_out=0, note_silent_out=1, note_valid_out=0, busy_out=0.
  - State=IDLE; candidate register=silence; match count=0.
  - freq_ready_out=1 once rst_n_in is high.
- Reset asserted mid-operation abandons the sample; no commit occurs.
- Handshake: transfer happens when freq_valid_in && freq_ready_out on a rising clk_in. freq_ready_out = (state==IDLE). Samples are never dropped or queued.
- IDLE: on transfer, latch freq_in into work register f and set oct=4.
  - If freq_in < MIN_FREQ or freq_in >= MAX_FREQ: result=silence, go to DECIDE.
  - Otherwise go to FOLD.
- FOLD: one operation per cycle.
  - If f >= 880: f = f>>1 (truncating), oct++.
  - Else if f < 440: f = f<<1, oct--.
  - Else go to SEARCH with idx=0.
  - Bounds on MIN/MAX_FREQ guarantee oct stays within 0..7. Maximum 4 FOLD shift cycles.
- SEARCH: one table compare per cycle, idx 0..11.
  - Table: 440, 466, 494, 523, 554, 587, 622, 659, 698, 740, 784, 831.
  - If f >= base[idx], record sel=idx. The largest passing idx wins (floor semantics).
  - After idx=11, go to DECIDE. SEARCH always takes exactly 12 cycles.
- DECIDE: result = map[sel] with octave field = oct[2:0].
  - map: A, A#, B, C, C#, D, D#, E, F, F#, G, G#.
  - Letters: A=000, B=001, C=010, D=011, E=100, F=101, G=110.
- Debounce, evaluated in DECIDE:
  - If result == candidate: count = min(count+1, 15). Otherwise: candidate=result, count=1.
  - If count (updated value) == STABLE_COUNT and candidate differs from the committed state: update note_code_out/note_silent_out and pulse note_valid_out the next cycle.
  - Silence commits with note_code_out=0.
  - Repeats of the already-committed note never re-pulse.
- DECIDE always returns to IDLE after one cycle.
- Latency, handshake to note_valid_out, for a committing sample:
  - 1 + F + 12 + 1 cycles, where F = shifts + 1 (the in-range check cycle), for in-range samples.
  - 2 cycles for silence samples.
- busy_out is high in FOLD, SEARCH and DECIDE.

Decomposition:
- Package note_pkg holds:
  - the note_code_t packed struct (letter[2:0], acc[1:0], oct[2:0]);
  - the BASE_FREQ[12] and NOTE_MAP[12] localparam arrays;
  - the state enum {IDLE, FOLD, SEARCH, DECIDE};
  - REF_LO=440 and REF_HI=880.
- One sub-module, note_debounce: candidate/count/commit logic, driven by a result strobe from the main FSM.

Test Plan:
- Three samples of 440, each handshaked after ready -> no pulse after samples 1–2; after sample 3, note_valid_out pulses once, note_code_out=8'h04, note_silent_out=0.
- Three samples of 1046 -> one FOLD shift to 523, oct=5, idx 3 -> note_code_out=8'h45 committed. A 4th sample of 1046 -> no pulse.
- Three samples of 100 -> folds to 800, oct=1 -> note_code_out=8'hC1. Measured latency from handshake to pulse = 1+4+12+1 = 18 cycles.
- Alternating samples 440, 220, 440, 220 -> never commits; state stays at reset silence; note_valid_out stays 0.
- After committing 8'h04, three samples of 20 Hz -> note_silent_out=1, note_code_out=0, one pulse. 7040 Hz behaves identically.
- Assert rst_n_in low mid-SEARCH with freq_valid_in held high -> outputs clear asynchronously; freq_ready_out=1 after release; no pulse for the aborted sample; count restarts from 0.
